// File: rtl/vfr_pkg.sv
// Shared types and constants for the VFR frame scheduler: FSM states,
// interlace nibbles, snooped packet type codes and the config record.
package vfr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_CTRL,
    ST_WAIT_VID
  } state_e;

  typedef enum logic {
    FIELD_F0,
    FIELD_F1
  } field_e;

  localparam logic [3:0] ILACE_PROG = 4'h3;
  localparam logic [3:0] ILACE_F0   = 4'h8;
  localparam logic [3:0] ILACE_F1   = 4'hC;

  localparam logic [3:0] PKT_CTRL  = 4'hF;
  localparam logic [3:0] PKT_VIDEO = 4'h0;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic        interlaced;
  } cfg_t;

  // An interlaced frame needs at least one line in each field.
  function automatic logic cfg_valid(input cfg_t c);
    return (c.width != 16'd0) && (c.height != 16'd0) &&
           (!c.interlaced || (c.height >= 16'd2));
  endfunction

endpackage

// File: rtl/vfr_frame_scheduler_if.sv
// Bundle of register-slave, encoder, reader and snooped-stream signals
// around the frame scheduler.
interface vfr_frame_scheduler_if #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int FRAME_CNT_W      = 16
);
  logic                                        go;
  logic                                        cfg_update;
  logic [15:0]                                 cfg_width;
  logic [15:0]                                 cfg_height;
  logic                                        cfg_interlaced;
  logic                                        do_control_packet;
  logic [15:0]                                 width;
  logic [15:0]                                 height;
  logic [3:0]                                  interlaced;
  logic                                        reader_start;
  logic [31:0]                                 frame_pixels;
  logic                                        snoop_valid;
  logic                                        snoop_ready;
  logic                                        snoop_sop;
  logic                                        snoop_eop;
  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] snoop_data;
  logic                                        busy;
  logic                                        cfg_error;
  logic [FRAME_CNT_W-1:0]                      frames_sent;

  modport slave (
    input  go, cfg_update, cfg_width, cfg_height, cfg_interlaced,
    input  snoop_valid, snoop_ready, snoop_sop, snoop_eop, snoop_data,
    output do_control_packet, width, height, interlaced,
    output reader_start, frame_pixels, busy, cfg_error, frames_sent
  );

  modport master (
    output go, cfg_update, cfg_width, cfg_height, cfg_interlaced,
    output snoop_valid, snoop_ready, snoop_sop, snoop_eop, snoop_data,
    input  do_control_packet, width, height, interlaced,
    input  reader_start, frame_pixels, busy, cfg_error, frames_sent
  );
endinterface

// File: rtl/vfr_stream_snoop.sv
// Watches the encoder's Avalon-ST output and flags the accepted end beat
// of control and video packets; packets of any other type are ignored.
module vfr_stream_snoop
  import vfr_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snoop_valid,
  input  logic              snoop_ready,
  input  logic              snoop_sop,
  input  logic              snoop_eop,
  input  logic [DATA_W-1:0] snoop_data,
  output logic              ctrl_end,
  output logic              video_end
);

  logic       in_ctrl_q, in_ctrl_d;
  logic       in_vid_q, in_vid_d;
  logic       beat;
  logic       cur_ctrl, cur_vid;
  logic [3:0] ptype;
  logic       unused_hi;

  assign unused_hi = ^snoop_data[DATA_W-1:4];

  always_comb begin
    beat     = snoop_valid & snoop_ready;
    ptype    = snoop_data[3:0];
    cur_ctrl = in_ctrl_q;
    cur_vid  = in_vid_q;
    // A sop beat classifies its own packet, so a single-beat packet can end itself.
    if (beat && snoop_sop) begin
      cur_ctrl = (ptype == PKT_CTRL);
      cur_vid  = (ptype == PKT_VIDEO);
    end
    ctrl_end  = beat & snoop_eop & cur_ctrl;
    video_end = beat & snoop_eop & cur_vid;
    in_ctrl_d = cur_ctrl & ~(beat & snoop_eop);
    in_vid_d  = cur_vid & ~(beat & snoop_eop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ctrl_q <= 1'b0;
      in_vid_q  <= 1'b0;
    end else begin
      in_ctrl_q <= in_ctrl_d;
      in_vid_q  <= in_vid_d;
    end
  end

endmodule

// File: rtl/vfr_frame_scheduler.sv
// Per-frame sequencer for the VFR output path: latch config, pulse the
// control packet encoder, start the reader, wait for the video packet end.
module vfr_frame_scheduler
  import vfr_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int FRAME_CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  vfr_frame_scheduler_if.slave bus
);

  state_e                 state_q, state_d;
  cfg_t                   pend_q, pend_d;
  cfg_t                   cfg_in;
  logic                   force_f0_q, force_f0_d;
  field_e                 field_q, field_d;
  field_e                 field_sel;
  logic                   act_il_q, act_il_d;
  logic [15:0]            width_q, width_d;
  logic [15:0]            height_q, height_d;
  logic [3:0]             ilace_q, ilace_d;
  logic [31:0]            pix_q, pix_d;
  logic                   rs_q, rs_d;
  logic [FRAME_CNT_W-1:0] fs_q, fs_d;
  logic                   err_q, err_d;
  logic [15:0]            h_out;
  logic [3:0]             nib;
  logic                   ctrl_end, video_end;

  vfr_stream_snoop #(
    .DATA_W(BITS_PER_SYMBOL * SYMBOLS_PER_BEAT)
  ) u_snoop (
    .clk         (clk),
    .rst_n       (rst_n),
    .snoop_valid (bus.snoop_valid),
    .snoop_ready (bus.snoop_ready),
    .snoop_sop   (bus.snoop_sop),
    .snoop_eop   (bus.snoop_eop),
    .snoop_data  (bus.snoop_data),
    .ctrl_end    (ctrl_end),
    .video_end   (video_end)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    force_f0_d = force_f0_q;
    field_d    = field_q;
    act_il_d   = act_il_q;
    width_d    = width_q;
    height_d   = height_q;
    ilace_d    = ilace_q;
    pix_d      = pix_q;
    rs_d       = 1'b0;
    fs_d       = fs_q;
    err_d      = err_q;

    cfg_in    = '{width: bus.cfg_width, height: bus.cfg_height,
                  interlaced: bus.cfg_interlaced};
    field_sel = force_f0_q ? FIELD_F0 : field_q;

    // F0 carries the extra line of an odd-height frame: (H+1)>>1 == (H>>1) + H[0].
    if (!pend_q.interlaced) begin
      h_out = pend_q.height;
      nib   = ILACE_PROG;
    end else if (field_sel == FIELD_F0) begin
      h_out = {1'b0, pend_q.height[15:1]} + {15'd0, pend_q.height[0]};
      nib   = ILACE_F0;
    end else begin
      h_out = {1'b0, pend_q.height[15:1]};
      nib   = ILACE_F1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.go && cfg_valid(pend_q)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        width_d    = pend_q.width;
        height_d   = h_out;
        ilace_d    = nib;
        pix_d      = {16'd0, pend_q.width} * {16'd0, h_out};
        act_il_d   = pend_q.interlaced;
        field_d    = field_sel;
        force_f0_d = 1'b0;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT_CTRL;
      ST_WAIT_CTRL: begin
        if (ctrl_end) begin
          rs_d    = 1'b1;
          state_d = ST_WAIT_VID;
        end
      end
      ST_WAIT_VID: begin
        if (video_end) begin
          fs_d = fs_q + 1'b1;
          if (act_il_q) field_d = (field_q == FIELD_F0) ? FIELD_F1 : FIELD_F0;
          state_d = bus.go ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the FSM so an update during LOAD re-arms the F0 restart.
    if (bus.cfg_update) begin
      pend_d = cfg_in;
      err_d  = !cfg_valid(cfg_in);
      if (cfg_in.interlaced != pend_q.interlaced) force_f0_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      force_f0_q <= 1'b0;
      field_q    <= FIELD_F0;
      act_il_q   <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      ilace_q    <= '0;
      pix_q      <= '0;
      rs_q       <= 1'b0;
      fs_q       <= '0;
      err_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      force_f0_q <= force_f0_d;
      field_q    <= field_d;
      act_il_q   <= act_il_d;
      width_q    <= width_d;
      height_q   <= height_d;
      ilace_q    <= ilace_d;
      pix_q      <= pix_d;
      rs_q       <= rs_d;
      fs_q       <= fs_d;
      err_q      <= err_d;
    end
  end

  assign bus.do_control_packet = (state_q == ST_ISSUE);
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.width             = width_q;
  assign bus.height            = height_q;
  assign bus.interlaced        = ilace_q;
  assign bus.frame_pixels      = pix_q;
  assign bus.reader_start      = rs_q;
  assign bus.frames_sent       = fs_q;
  assign bus.cfg_error         = err_q;

endmodule

// File: tb/tb_vfr_frame_scheduler.sv
// Self-checking bench for vfr_frame_scheduler: acts as register slave and
// encoder, compares against constants and a frame-level reference model.
module tb_vfr_frame_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vfr_frame_scheduler_if #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .FRAME_CNT_W(3)) bus ();

  vfr_frame_scheduler #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(3),
    .FRAME_CNT_W     (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int fs_exp = 0;

  // Reference model state: pending config, field parity, restart flag.
  int m_w = 0, m_h = 0;
  bit m_il = 0, m_force = 0, m_field = 0, m_act_il = 0;

  typedef struct { int w; int h; bit il; bit err; } vcase_t;
  typedef struct { int h; int nib; int pix; } fexp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_update(input int w, input int h, input bit il);
    if (il != m_il) m_force = 1;
    m_w = w; m_h = h; m_il = il;
  endfunction

  function automatic void model_start(output int ew, output int eh, output int enib, output int epix);
    if (m_force) begin m_field = 0; m_force = 0; end
    m_act_il = m_il;
    ew = m_w;
    if (!m_il) begin eh = m_h; enib = 3; end
    else if (!m_field) begin eh = (m_h + 1) / 2; enib = 8; end
    else begin eh = m_h / 2; enib = 12; end
    epix = ew * eh;
  endfunction

  function automatic void model_end();
    if (m_act_il) m_field = !m_field;
  endfunction

  task automatic do_cfg(input int w, input int h, input bit il);
    bus.cfg_update = 1; bus.cfg_width = 16'(w); bus.cfg_height = 16'(h); bus.cfg_interlaced = il;
    model_update(w, h, il);
    tick();
    bus.cfg_update = 0;
  endtask

  task automatic stream_idle();
    bus.snoop_valid = 0; bus.snoop_sop = 0; bus.snoop_eop = 0;
    bus.snoop_data = '0; bus.snoop_ready = 1;
  endtask

  task automatic send_pkt(input logic [3:0] ptype, input int nbeats, input int rmode,
                          input bit upd_en, input int uw, input int uh, input bit uil,
                          output bit rs_early);
    int  i = 0;
    int  cyc = 0;
    bit  acc;
    rs_early = 0;
    while (i < nbeats && cyc < 200) begin
      bus.snoop_valid = 1;
      bus.snoop_sop   = (i == 0);
      bus.snoop_eop   = (i == nbeats - 1);
      bus.snoop_data  = (i == 0) ? {20'($urandom), ptype} : 24'($urandom);
      case (rmode)
        0:       bus.snoop_ready = 1;
        1:       bus.snoop_ready = (cyc % 2 == 0);
        default: bus.snoop_ready = 1'($urandom_range(0, 1));
      endcase
      if (upd_en && cyc == 1) begin
        bus.cfg_update = 1; bus.cfg_width = 16'(uw); bus.cfg_height = 16'(uh);
        bus.cfg_interlaced = uil;
        model_update(uw, uh, uil);
      end else begin
        bus.cfg_update = 0;
      end
      acc = bus.snoop_ready;
      tick();
      cyc++;
      if (acc) i++;
      if (!(acc && i == nbeats) && bus.reader_start) rs_early = 1;
    end
    chk("pkt_done", i, nbeats);
    bus.cfg_update = 0;
    stream_idle();
  endtask

  task automatic wait_dcp(output int lat);
    lat = 0;
    while (!bus.do_control_packet && lat < 40) begin
      tick();
      lat++;
    end
    chk("dcp_seen", bus.do_control_packet, 1);
  endtask

  task automatic run_frame(input int ew, input int eh, input int enib, input int epix,
                           input int exp_lat, input int rmode, input bit junk, input bit go_after,
                           input bit upd_en, input int uw, input int uh, input bit uil);
    int lat;
    bit rs_e;
    wait_dcp(lat);
    if (exp_lat >= 0) chk("go_to_dcp_latency", lat, exp_lat);
    chk("dcp_width", bus.width, ew);
    chk("dcp_height", bus.height, eh);
    chk("dcp_nibble", bus.interlaced, enib);
    tick();
    chk("dcp_single", bus.do_control_packet, 0);
    chk("height_stable", bus.height, eh);
    if (junk) begin
      send_pkt(4'h5, 3, rmode, 0, 0, 0, 0, rs_e);
      chk("junk_no_reader_start", {31'd0, rs_e | bus.reader_start}, 0);
    end
    send_pkt(4'hF, 3, rmode, 0, 0, 0, 0, rs_e);
    chk("reader_start_early", rs_e, 0);
    chk("reader_start_after_eop", bus.reader_start, 1);
    chk("frame_pixels", bus.frame_pixels, epix);
    bus.go = go_after;
    tick();
    chk("reader_start_single", bus.reader_start, 0);
    chk("frames_sent_before_vid", bus.frames_sent, fs_exp);
    send_pkt(4'h0, 4, rmode, upd_en, uw, uh, uil, rs_e);
    chk("reader_start_during_vid", rs_e, 0);
    fs_exp = (fs_exp + 1) % 8;
    chk("frames_sent", bus.frames_sent, fs_exp);
  endtask

  initial begin
    vcase_t vt[6];
    fexp_t  it[3];
    bit     any;
    int     ew, eh, enib, epix;

    vt[0] = '{w: 0,   h: 480, il: 0, err: 1};
    vt[1] = '{w: 640, h: 0,   il: 0, err: 1};
    vt[2] = '{w: 720, h: 1,   il: 1, err: 1};
    vt[3] = '{w: 720, h: 1,   il: 0, err: 0};
    vt[4] = '{w: 720, h: 2,   il: 1, err: 0};
    vt[5] = '{w: 640, h: 480, il: 0, err: 0};
    it[0] = '{h: 244, nib: 8,  pix: 175680};
    it[1] = '{h: 243, nib: 12, pix: 174960};
    it[2] = '{h: 244, nib: 8,  pix: 175680};

    rst_n = 0; bus.go = 0; bus.cfg_update = 0; bus.cfg_width = 0; bus.cfg_height = 0;
    bus.cfg_interlaced = 0;
    stream_idle();
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("rst_dcp", bus.do_control_packet, 0);
    chk("rst_reader_start", bus.reader_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_width", bus.width, 0);
    chk("rst_height", bus.height, 0);
    chk("rst_interlaced", bus.interlaced, 0);
    chk("rst_frame_pixels", bus.frame_pixels, 0);
    chk("rst_frames_sent", bus.frames_sent, 0);
    chk("rst_cfg_error", bus.cfg_error, 1);

    for (int i = 0; i < 6; i++) begin
      do_cfg(vt[i].w, vt[i].h, vt[i].il);
      chk("cfg_error_table", bus.cfg_error, vt[i].err);
      chk("busy_table", bus.busy, 0);
    end

    // Invalid interlaced config with go held: nothing may start.
    do_cfg(720, 1, 1);
    chk("cfg_error_invalid", bus.cfg_error, 1);
    bus.go = 1;
    any = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.busy || bus.do_control_packet || bus.reader_start) any = 1;
    end
    chk("invalid_no_activity", any, 0);
    bus.go = 0;
    do_cfg(640, 480, 0);
    chk("cfg_error_cleared", bus.cfg_error, 0);

    // Progressive 640x480; go dropped during the video packet.
    bus.go = 1;
    run_frame(640, 480, 3, 307200, 2, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_after_go_drop", bus.busy, 0);
    any = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.do_control_packet || bus.busy) any = 1;
    end
    chk("stays_idle", any, 0);

    // Interlaced 720x487, three fields.
    do_cfg(720, 487, 1);
    bus.go = 1;
    for (int i = 0; i < 3; i++)
      run_frame(720, it[i].h, it[i].nib, it[i].pix, (i == 0) ? 2 : -1, 0, 0, (i < 2), 0, 0, 0, 0);
    chk("idle_after_fields", bus.busy, 0);

    // Backpressure 1010 with a foreign packet, then a mid-video resize.
    do_cfg(640, 480, 0);
    bus.go = 1;
    run_frame(640, 480, 3, 307200, 2, 1, 1, 1, 1, 1920, 1080, 0);
    run_frame(1920, 1080, 3, 2073600, -1, 0, 0, 0, 0, 0, 0, 0);

    // Reset while waiting for the control packet end.
    do_cfg(100, 50, 0);
    bus.go = 1;
    wait_dcp(ew);
    tick();
    bus.snoop_valid = 1; bus.snoop_sop = 1; bus.snoop_data = 24'h00000F;
    tick();
    stream_idle();
    chk("wait_ctrl_busy", bus.busy, 1);
    bus.go = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_dcp", bus.do_control_packet, 0);
    chk("mid_rst_reader_start", bus.reader_start, 0);
    chk("mid_rst_width", bus.width, 0);
    chk("mid_rst_height", bus.height, 0);
    chk("mid_rst_interlaced", bus.interlaced, 0);
    chk("mid_rst_frame_pixels", bus.frame_pixels, 0);
    chk("mid_rst_frames_sent", bus.frames_sent, 0);
    tick();
    chk("post_rst_idle", bus.busy, 0);

    // Randomized frames against the frame-level model.
    fs_exp = 0;
    m_w = 0; m_h = 0; m_il = 0; m_force = 0; m_field = 0; m_act_il = 0;
    begin
      int  rw, rh;
      bit  ril;
      rw = $urandom_range(1, 4000); ril = 1'($urandom_range(0, 1));
      rh = ril ? $urandom_range(2, 2000) : $urandom_range(1, 2000);
      do_cfg(rw, rh, ril);
      bus.go = 1;
      for (int f = 0; f < 12; f++) begin
        bit ue;
        model_start(ew, eh, enib, epix);
        ue = 1'($urandom_range(0, 1));
        rw = $urandom_range(1, 4000); ril = 1'($urandom_range(0, 1));
        rh = ril ? $urandom_range(2, 2000) : $urandom_range(1, 2000);
        run_frame(ew, eh, enib, epix, (f == 0) ? 2 : -1, 2, 1'($urandom_range(0, 1)),
                  (f < 11), ue, rw, rh, ril);
        model_end();
      end
    end
    tick();
    chk("random_end_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
